// File: rtl/alu_pkg.sv
// Shared definitions for the execute-stage ALU: default width, ALU_Control
// codes (also used by ALU control) and the execute FSM state encoding.
package alu_pkg;

  localparam int ALU_WIDTH = 16;
  localparam int ALU_CNT_W = 4;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b100;
  localparam logic [2:0] ALU_MUL = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_HOLD = 2'd2
  } alu_state_t;

endpackage

// File: rtl/mul_seq16.sv
// Iterative shift-add unsigned multiplier: one multiplier bit per cycle,
// WIDTH iterations. done marks the final iteration; product is valid then.
module mul_seq16 #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 abort,
  input  logic                 start,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] mcand_sh;
  logic [2*WIDTH-1:0] addend;
  logic [WIDTH-1:0]   mplier;
  logic [CNT_W-1:0]   cnt;

  // mcand_sh always holds multiplicand << cnt, so no barrel shifter is needed.
  always_comb begin
    addend  = mplier[cnt] ? mcand_sh : '0;
    product = acc + addend;
    done    = busy && (cnt == LAST);
  end

  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy     <= 1'b0;
      acc      <= '0;
      mcand_sh <= '0;
      mplier   <= '0;
      cnt      <= '0;
    end else if (abort) begin
      busy <= 1'b0;
      cnt  <= '0;
    end else if (start) begin
      busy     <= 1'b1;
      acc      <= '0;
      mcand_sh <= {{WIDTH{1'b0}}, multiplicand};
      mplier   <= multiplier;
      cnt      <= '0;
    end else if (busy) begin
      acc      <= product;
      mcand_sh <= mcand_sh << 1;
      cnt      <= cnt + CNT_W'(1);
      if (done) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: single-cycle ADD/SUB/AND/OR/SLT and a multi-cycle MUL,
// with valid/ready handshakes and registered result/hi/zero/ovf.
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH,
  parameter int CNT_W = ALU_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       alu_ctrl,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] hi,
  output logic             zero,
  output logic             ovf
);

  alu_state_t state, state_nxt;

  logic accept, accept_mul, accept_single;
  logic mul_busy, mul_done;
  logic [2*WIDTH-1:0] mul_product;

  logic [WIDTH-1:0] sum, diff, alu_res;
  logic             alu_ovf;

  mul_seq16 #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_mul (
    .clk          (clk),
    .rst_n        (rst_n),
    .abort        (flush),
    .start        (accept_mul),
    .multiplicand (op_a),
    .multiplier   (op_b),
    .busy         (mul_busy),
    .done         (mul_done),
    .product      (mul_product)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = ST_IDLE;
    end else begin
      unique case (state)
        ST_IDLE: if (accept_mul) state_nxt = ST_MUL;
        ST_MUL: begin
          if (mul_done)       state_nxt = ST_HOLD;
          else if (!mul_busy) state_nxt = ST_IDLE;
        end
        ST_HOLD: if (out_ready) state_nxt = ST_IDLE;
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  // Handshake: rst_n and flush gate in_ready so nothing is accepted while aborting.
  always_comb begin
    in_ready      = rst_n && !flush && (state == ST_IDLE) && (!out_valid || out_ready);
    accept        = in_valid && in_ready;
    accept_mul    = accept && (alu_ctrl == ALU_MUL);
    accept_single = accept && (alu_ctrl != ALU_MUL);
  end

  // NOTE: defaults first so no path through the case can infer a latch.
  always_comb begin
    sum     = op_a + op_b;
    diff    = op_a - op_b;
    alu_res = '0;
    alu_ovf = 1'b0;
    case (alu_ctrl)
      ALU_ADD: begin
        alu_res = sum;
        alu_ovf = (op_a[WIDTH-1] == op_b[WIDTH-1]) && (sum[WIDTH-1] != op_a[WIDTH-1]);
      end
      ALU_SUB: begin
        alu_res = diff;
        alu_ovf = (op_a[WIDTH-1] != op_b[WIDTH-1]) && (diff[WIDTH-1] != op_a[WIDTH-1]);
      end
      ALU_AND: alu_res = op_a & op_b;
      ALU_OR:  alu_res = op_a | op_b;
      ALU_SLT: alu_res = WIDTH'($signed(op_a) < $signed(op_b));
      default: alu_res = '0;
    endcase
  end

  // Output registers: flush wins, then new data, then release on out_ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      result    <= '0;
      hi        <= '0;
      zero      <= 1'b0;
      ovf       <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept_single) begin
      out_valid <= 1'b1;
      result    <= alu_res;
      hi        <= '0;
      zero      <= (alu_res == '0);
      ovf       <= alu_ovf;
    end else if (mul_done && state == ST_MUL) begin
      out_valid <= 1'b1;
      result    <= mul_product[WIDTH-1:0];
      hi        <= mul_product[2*WIDTH-1:WIDTH];
      zero      <= (mul_product[WIDTH-1:0] == '0);
      ovf       <= 1'b0;
    end else if (accept_mul || (out_valid && out_ready)) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: directed corner cases plus random
// operations compared against an arithmetic reference model.
module tb_alu_exec_unit;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, in_ready, out_valid, out_ready, zero, ovf;
  logic [2:0]  alu_ctrl;
  logic [15:0] op_a, op_b, result, hi;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [15:0] res;
    logic [15:0] hi;
    logic        zero;
    logic        ovf;
  } exp_t;

  alu_exec_unit dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .alu_ctrl  (alu_ctrl),
    .op_a      (op_a),
    .op_b      (op_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .hi        (hi),
    .zero      (zero),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // Reference model: signed/unsigned integer arithmetic on the op definitions.
  function automatic exp_t model(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    exp_t        e;
    int          sa, sb, s;
    int unsigned ua, ub, p;
    sa = int'($signed(a));
    sb = int'($signed(b));
    ua = int'(a);
    ub = int'(b);
    e  = '0;
    case (op)
      3'd0: begin s = sa + sb; e.res = s[15:0]; e.ovf = (s > 32767) || (s < -32768); end
      3'd1: begin s = sa - sb; e.res = s[15:0]; e.ovf = (s > 32767) || (s < -32768); end
      3'd2: e.res = a & b;
      3'd3: e.res = a | b;
      3'd4: e.res = (sa < sb) ? 16'd1 : 16'd0;
      3'd5: begin p = ua * ub; e.res = p[15:0]; e.hi = p[31:16]; end
      default: e.res = 16'd0;
    endcase
    e.zero = (e.res == 16'd0);
    return e;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input exp_t e);
    check(tag, {out_valid, ovf, zero, hi, result}, {1'b1, e.ovf, e.zero, e.hi, e.res});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (!in_ready && n < 60) begin
      tick();
      n++;
    end
    check(tag, in_ready, 1'b1);
  endtask

  task automatic single(input string tag, input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    wait_ready({tag, "_wait"});
    in_valid = 1'b1;
    alu_ctrl = op;
    op_a     = a;
    op_b     = b;
    tick();
    in_valid = 1'b0;
    check_out(tag, model(op, a, b));
  endtask

  task automatic run_mul(input string tag, input logic [15:0] a, input logic [15:0] b);
    int   cyc = 0;
    logic saw_ready = 1'b0;
    wait_ready({tag, "_wait"});
    in_valid = 1'b1;
    alu_ctrl = 3'd5;
    op_a     = a;
    op_b     = b;
    tick();
    in_valid = 1'b0;
    while (!out_valid && cyc < 40) begin
      if (in_ready) saw_ready = 1'b1;
      tick();
      cyc++;
    end
    check({tag, "_latency"}, 64'(cyc), 64'd16);
    check({tag, "_busy_ready"}, saw_ready, 1'b0);
    check_out(tag, model(3'd5, a, b));
  endtask

  initial begin
    exp_t        e;
    logic [2:0]  op;
    logic [15:0] a, b;
    logic        saw;

    rst_n     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    alu_ctrl  = 3'd0;
    op_a      = 16'd0;
    op_b      = 16'd0;
    out_ready = 1'b1;

    #2;
    check("reset_outputs", {out_valid, ovf, zero, hi, result}, 64'd0);
    check("reset_in_ready", in_ready, 1'b0);
    #10 rst_n = 1'b1;
    tick();

    // Directed single-cycle corner cases.
    single("add_ovf", 3'd0, 16'h7FFF, 16'h0001);
    check("add_ovf_const", {ovf, zero, result}, {1'b1, 1'b0, 16'h8000});
    single("sub_zero", 3'd1, 16'h0005, 16'h0005);
    check("sub_zero_const", {ovf, zero, result}, {1'b0, 1'b1, 16'h0000});
    single("slt_neg", 3'd4, 16'hFFFF, 16'h0001);
    check("slt_neg_const", result, 16'h0001);
    single("and", 3'd2, 16'hF0F0, 16'h0FF0);
    check("and_const", result, 16'h00F0);
    single("or", 3'd3, 16'hF0F0, 16'h0FF0);
    check("or_const", result, 16'hFFF0);
    single("rsvd110", 3'd6, 16'h1234, 16'h5678);
    single("sub_ovf", 3'd1, 16'h8000, 16'h0001);

    // Back-to-back random single-cycle ops, one per cycle.
    tick();
    for (int i = 0; i < 24; i++) begin
      op = 3'($urandom_range(0, 6));
      if (op == 3'd5) op = 3'd7;
      a = 16'($urandom);
      b = 16'($urandom);
      if (i % 6 == 0) b = a;
      in_valid = 1'b1;
      alu_ctrl = op;
      op_a     = a;
      op_b     = b;
      check("b2b_ready", in_ready, 1'b1);
      tick();
      check_out("b2b_out", model(op, a, b));
    end
    in_valid = 1'b0;
    tick();

    // Multiply: worst-case operands, then random.
    run_mul("mul_max", 16'hFFFF, 16'hFFFF);
    check("mul_max_const", {hi, result}, {16'hFFFE, 16'h0001});
    for (int i = 0; i < 4; i++) run_mul("mul_rand", 16'($urandom), 16'($urandom));

    // Multiply result held under back-pressure.
    tick();
    out_ready = 1'b0;
    a = 16'($urandom);
    b = 16'($urandom);
    run_mul("mul_hold", a, b);
    e = model(3'd5, a, b);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_out("mul_hold_stable", e);
      check("mul_hold_ready", in_ready, 1'b0);
    end
    out_ready = 1'b1;
    tick();
    check("mul_release_valid", out_valid, 1'b0);
    check("mul_release_ready", in_ready, 1'b1);

    // Single-cycle back-pressure, then release with same-edge accept.
    out_ready = 1'b0;
    single("bp_add", 3'd0, 16'd3, 16'd4);
    for (int i = 0; i < 5; i++) begin
      tick();
      check_out("bp_add_stable", model(3'd0, 16'd3, 16'd4));
      check("bp_ready_low", in_ready, 1'b0);
    end
    a = 16'($urandom);
    b = 16'($urandom);
    in_valid  = 1'b1;
    alu_ctrl  = 3'd1;
    op_a      = a;
    op_b      = b;
    out_ready = 1'b1;
    #1;
    check("bp_release_ready", in_ready, 1'b1);
    tick();
    in_valid = 1'b0;
    check_out("bp_next_op", model(3'd1, a, b));
    tick();

    // Flush discards a held single-cycle result.
    out_ready = 1'b0;
    single("flush_hold_or", 3'd3, 16'h00A5, 16'h5A00);
    flush = 1'b1;
    #1;
    check("flush_in_ready", in_ready, 1'b0);
    tick();
    flush = 1'b0;
    check("flush_hold_valid", out_valid, 1'b0);
    out_ready = 1'b1;

    // Flush at MUL iteration 8.
    wait_ready("flush_mul_wait");
    in_valid = 1'b1;
    alu_ctrl = 3'd5;
    op_a     = 16'h1234;
    op_b     = 16'hFFFF;
    tick();
    in_valid = 1'b0;
    repeat (7) tick();
    flush = 1'b1;
    #1;
    check("flush_mul_in_ready", in_ready, 1'b0);
    tick();
    flush = 1'b0;
    saw = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (out_valid) saw = 1'b1;
      tick();
    end
    check("flush_mul_no_valid", saw, 1'b0);
    single("after_flush_add", 3'd0, 16'd1, 16'd1);
    check("after_flush_const", result, 16'h0002);
    tick();

    // Asynchronous reset in the middle of a multiply.
    wait_ready("rst_mul_wait");
    in_valid = 1'b1;
    alu_ctrl = 3'd5;
    op_a     = 16'h00FF;
    op_b     = 16'h0F0F;
    tick();
    in_valid = 1'b0;
    repeat (5) tick();
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_outputs", {out_valid, ovf, zero, hi, result}, 64'd0);
    check("rst_mid_in_ready", in_ready, 1'b0);
    #2 rst_n = 1'b1;
    saw = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (out_valid) saw = 1'b1;
    end
    check("rst_no_residual", saw, 1'b0);
    run_mul("mul_3x5", 16'd3, 16'd5);
    check("mul_3x5_const", {hi, result}, {16'h0000, 16'h000F});

    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
- Execute-stage ALU for the 16-bit MIPS datapath; sits directly downstream of ALU control and consumes its 3-bit ALU_Control code plus both register operands.
- ADD/SUB/AND/OR/SLT complete in one cycle; MUL is a 16-iteration shift-add operation.
- Valid/ready handshakes on input and output; the decode/hazard logic stalls on in_ready low.
- Produces a registered result, a zero flag (branch compare) and signed overflow.

Parameters:
- WIDTH, 16, operand/result width; MUL iteration count equals WIDTH.
- CNT_W, 4, iteration counter width, equal to clog2(WIDTH).

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- flush  input  1  synchronous abort of the in-flight op and of the held result.
- in_valid  input  1  operands and alu_ctrl are valid.
- in_ready  output  1  unit can accept this cycle.
- alu_ctrl  input  3  ALU_Control code from ALU control.
- op_a  input  WIDTH  rs operand.
- op_b  input  WIDTH  rt operand or immediate.
- out_valid  output  1  result, hi, zero and ovf are valid.
- out_ready  input  1  consumer accepts the result.
- result  output  WIDTH  ALU result; low half of the MUL product.
- hi  output  WIDTH  high half of the MUL product; 0 for all other ops.
- zero  output  1  result == 0.
- ovf  output  1  signed overflow; ADD/SUB only.

Behaviour:
- Reset (async, rst_n=0): state IDLE; out_valid=0, result=0, hi=0, zero=0, ovf=0; counter and accumulator cleared; in_ready=0 while rst_n=0.
- Op codes: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 SLT (signed; result 1 or 0), 101 MUL (unsigned 16x16 to 32), 110 and 111 reserved (single-cycle, result=0, ovf=0).
- in_ready = (state==IDLE) && (!out_valid || out_ready). An input is accepted on in_valid && in_ready.
- Single-cycle ops:
  - Output registers load on the accepting edge, so out_valid rises the next cycle (latency 1).
  - Back-to-back throughput is 1 per cycle while out_ready=1.
- ADD/SUB:
  - Results wrap modulo 2^16.
  - ADD ovf = (a[15]==b[15]) && (r[15]!=a[15]).
  - SUB ovf = (a[15]!=b[15]) && (r[15]!=a[15]).
- FSM states: IDLE, MUL, HOLD.
  - IDLE: accepting MUL captures the operands, clears the accumulator, sets cnt=0, goes to MUL. out_valid drops on that edge unless a pending result is still unconsumed, which in_ready prevents.
  - MUL: each cycle, if multiplier bit [cnt]=1, add the shifted multiplicand into the 32-bit accumulator; cnt++. When cnt==WIDTH-1, load result/hi from the final accumulator, set out_valid=1, go to HOLD.
  - HOLD: stay while out_valid && !out_ready; on out_ready, return to IDLE.
  - MUL latency: 16 cycles from the accepting edge to out_valid=1; in_ready=0 throughout.
- Output hold: while out_valid=1 && out_ready=0, result, hi, zero and ovf stay stable.
- Output release: out_valid falls on the edge where out_ready=1, unless a new single-cycle op is accepted on that same edge, in which case out_valid stays 1 with new data.
- flush=1 (priority over in_valid): clears out_valid, returns to IDLE and discards any MUL in progress; in_ready is forced to 0 that cycle.
- Reset mid-MUL: aborts immediately with no residual output.
- zero and ovf are registered together with result; hi=0 for non-MUL ops.

Decomposition:
- alu_pkg holds:
  - WIDTH default.
  - ALU_ADD/SUB/AND/OR/SLT/MUL 3-bit localparams, shared with ALU control.
  - FSM state encodings.
- Sub-module mul_seq16 holds the shift-add datapath: start, operands, busy, done, 32-bit product. The FSM and output registers stay in alu_exec_unit.

Test Plan:
- ADD 0x7FFF+0x0001, out_ready=1 -> next cycle result=0x8000, ovf=1, zero=0; SUB 0x0005-0x0005 -> result=0x0000, zero=1, ovf=0.
- SLT a=0xFFFF (-1), b=0x0001 -> result=0x0001; AND 0xF0F0&0x0FF0 -> 0x00F0; OR -> 0xFFF0; code 110 -> result=0.
- MUL 0xFFFF*0xFFFF -> out_valid exactly 16 cycles after accept, hi=0xFFFE, result=0x0001; in_ready=0 for those 16 cycles.
- Back-pressure: ADD 3+4 with out_ready=0 for 5 cycles -> result=0x0007 held stable, in_ready=0; out_ready=1 -> accept, next op accepted that same cycle.
- flush asserted at MUL iteration 8 -> out_valid never rises for that op; the next ADD 1+1 gives result=0x0002 one cycle later.
- rst_n pulsed low mid-MUL (async, between edges) -> all outputs 0 immediately; after release, MUL 3*5 -> hi=0, result=0x000F.
